alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
Command front-end that sits directly upstream of ALU_TOP and consumes its results. Accepts ALU commands over a valid/ready handshake and fetches both operands from a small local register file. It drives A/B/ALU_FUN into ALU_TOP, waits the ALU's registered latency, and captures the output of the unit whose flag is set. It then optionally writes the result back to the register file and returns it on a valid/ready response channel.

Parameters:
WIDTH_IN_DATA, 16, operand / register width
WIDTH_OUT_DATA_ARITH, 32, ALU arithmetic result width; response data width
WIDTH_OUT_DATA_LOGIC, 16, ALU logic result width
WIDTH_OUT_DATA_CMP, 16, ALU compare result width
WIDTH_OUT_DATA_SHIFT, 16, ALU shift result width
ADDR_WIDTH, 3, register file address width (2**ADDR_WIDTH registers)
ALU_LAT, 1, ALU cycles from input sample edge to valid registered output (>=1)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command
cmd_op  in  4  ALU_FUN code
cmd_src_a / cmd_src_b  in  ADDR_WIDTH  operand register addresses
cmd_dst  in  ADDR_WIDTH  writeback address
cmd_wb_en  in  1  write result back to cmd_dst
wr_en  in  1  host register write
wr_addr  in  ADDR_WIDTH  host write address
wr_data  in  WIDTH_IN_DATA  host write data
ALU_A / ALU_B  out  WIDTH_IN_DATA  operands to ALU_TOP (registered)
ALU_FUN  out  4  function to ALU_TOP (registered)
Arith_OUT  in  WIDTH_OUT_DATA_ARITH  ALU arithmetic result (signed)
Logic_OUT / CMP_OUT / SHIFT_OUT  in  16 each  ALU unit results
Arith_Flag / Logic_Flag / CMP_Flag / SHIFT_Flag  in  1 each  ALU unit-valid flags
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_data  out  WIDTH_OUT_DATA_ARITH  captured result
rsp_err  out  1  expected ALU flag absent at capture

Behaviour:
- Reset (RST=0, async): state IDLE; cmd_ready=1 after release; ALU_A/ALU_B/ALU_FUN=0; rsp_valid=0, rsp_data=0, rsp_err=0; all registers 0; wait counter 0. Mid-operation reset aborts the in-flight command with no writeback and no response.
- FSM IDLE -> WAIT -> RESP -> IDLE. cmd_ready = (state==IDLE), combinational from state.
- IDLE: on an edge with cmd_valid&&cmd_ready, register ALU_A=reg[cmd_src_a] and ALU_B=reg[cmd_src_b] (combinational read, pre-write values), ALU_FUN=cmd_op. Latch dst, wb_en, and expected unit = cmd_op[3:2]. Load cnt=ALU_LAT. Go to WAIT.
- WAIT: ALU inputs held stable. While cnt!=0, decrement each edge. On the edge with cnt==0, capture:
  - unit 00 (Arith_Flag): rsp_data=Arith_OUT.
  - unit 01 (Logic_Flag), 10 (CMP_Flag), 11 (SHIFT_Flag): rsp_data = respective 16-bit output, zero-extended.
  - If the expected flag is 0: rsp_err=1, rsp_data=0, no writeback.
  - Otherwise rsp_err=0; if wb_en, reg[dst] <= rsp_data[WIDTH_IN_DATA-1:0].
  - Go to RESP with rsp_valid=1.
- Latency: rsp_valid rises ALU_LAT+1 edges after the accepting edge (2 with defaults).
- RESP: rsp_valid/rsp_data/rsp_err held stable until an edge with rsp_ready=1; then rsp_valid=0 and state IDLE. Minimum command spacing is ALU_LAT+3 cycles.
- Host write port is active in every state. A host write to the same address as a capture writeback in the same edge loses to the writeback. Host writes after the accept edge do not affect the in-flight operands.
- cmd_src_a==cmd_src_b is legal. cmd_dst may equal a source.
- rsp_data is not updated outside the capture edge.

Decomposition:
- Package alu_seq_pkg: state encoding (IDLE, WAIT, RESP), unit codes (UNIT_ARITH=2'b00, UNIT_LOGIC=01, UNIT_CMP=10, UNIT_SHIFT=11), ALU_FUN opcode constants 0000..1111.
- One sub-module, alu_seq_regfile: 2**ADDR_WIDTH x WIDTH_IN_DATA flops, two combinational read ports, and two write ports with the writeback port taking priority. Async active-low reset to 0.

Test Plan:
1. Host writes r0=0xFFFB, r1=0xFFF9; cmd op=0000, a=0, b=1, dst=2, wb=1 -> rsp_valid 2 cycles after accept, rsp_data=0xFFFFFFF4, rsp_err=0; r2 then read as operand = 0xFFF4.
2. r0=0xFFFB, r3=0x0007; op=0010 (mult) -> rsp_data=0xFFFFFFDD. Then op=0001, a=3, b=0 -> 0x0000000C.
3. r4=0x0005; op=1100 (shift A right), a=4 -> rsp_data=0x00000002. op=0101 (OR), a=4, b=3 -> 0x00000007.
4. Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data stable, cmd_ready=0 throughout; after release, cmd_ready=1 on the next cycle and a back-to-back command is accepted.
5. ALU model forces Logic_Flag=0 on op=0100 with wb=1, dst=5 -> rsp_err=1, rsp_data=0, r5 unchanged. A host write to r2 coincident with the op-0000 writeback to r2 -> writeback value retained.
6. Assert RST=0 while in WAIT -> immediately rsp_valid=0, ALU_FUN=0, all registers 0. After release cmd_ready=1 and no response is emitted for the aborted command.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer: FSM states,
// ALU unit selectors and the ALU_FUN opcode map of the downstream ALU.
package alu_seq_pkg;

    localparam int OP_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } seq_state_t;

    // Upper two opcode bits select which ALU unit produces the result.
    typedef enum logic [1:0] {
        UNIT_ARITH = 2'b00,
        UNIT_LOGIC = 2'b01,
        UNIT_CMP   = 2'b10,
        UNIT_SHIFT = 2'b11
    } alu_unit_t;

    localparam logic [OP_WIDTH-1:0] OP_ADD    = 4'b0000;
    localparam logic [OP_WIDTH-1:0] OP_SUB    = 4'b0001;
    localparam logic [OP_WIDTH-1:0] OP_MUL    = 4'b0010;
    localparam logic [OP_WIDTH-1:0] OP_DIV    = 4'b0011;
    localparam logic [OP_WIDTH-1:0] OP_AND    = 4'b0100;
    localparam logic [OP_WIDTH-1:0] OP_OR     = 4'b0101;
    localparam logic [OP_WIDTH-1:0] OP_NAND   = 4'b0110;
    localparam logic [OP_WIDTH-1:0] OP_NOR    = 4'b0111;
    localparam logic [OP_WIDTH-1:0] OP_NOP    = 4'b1000;
    localparam logic [OP_WIDTH-1:0] OP_CMP_EQ = 4'b1001;
    localparam logic [OP_WIDTH-1:0] OP_CMP_GT = 4'b1010;
    localparam logic [OP_WIDTH-1:0] OP_CMP_LT = 4'b1011;
    localparam logic [OP_WIDTH-1:0] OP_SHR_A  = 4'b1100;
    localparam logic [OP_WIDTH-1:0] OP_SHL_A  = 4'b1101;
    localparam logic [OP_WIDTH-1:0] OP_SHR_B  = 4'b1110;
    localparam logic [OP_WIDTH-1:0] OP_SHL_B  = 4'b1111;

    // Unit whose flag is expected to accompany the result of an opcode.
    function automatic alu_unit_t op_unit(input logic [OP_WIDTH-1:0] op);
        return alu_unit_t'(op[3:2]);
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Host-facing bundle of the sequencer: command channel, host register
// write port and response channel. The host drives through master, the
// sequencer implements slave.
interface alu_cmd_sequencer_if
    import alu_seq_pkg::*;
#(
    parameter int WIDTH_IN_DATA        = 16,
    parameter int WIDTH_OUT_DATA_ARITH = 32,
    parameter int ADDR_WIDTH           = 3
);
    logic                            cmd_valid;
    logic                            cmd_ready;
    logic [OP_WIDTH-1:0]             cmd_op;
    logic [ADDR_WIDTH-1:0]           cmd_src_a;
    logic [ADDR_WIDTH-1:0]           cmd_src_b;
    logic [ADDR_WIDTH-1:0]           cmd_dst;
    logic                            cmd_wb_en;

    logic                            wr_en;
    logic [ADDR_WIDTH-1:0]           wr_addr;
    logic [WIDTH_IN_DATA-1:0]        wr_data;

    logic                            rsp_valid;
    logic                            rsp_ready;
    logic [WIDTH_OUT_DATA_ARITH-1:0] rsp_data;
    logic                            rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dst, cmd_wb_en,
        output wr_en, wr_addr, wr_data,
        output rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dst, cmd_wb_en,
        input  wr_en, wr_addr, wr_data,
        input  rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/alu_seq_regfile.sv
// Small operand register file: flop array with two combinational read
// ports and two write ports. The result writeback port wins over the host
// port when both hit the same register on the same edge.
module alu_seq_regfile #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    output logic [DATA_WIDTH-1:0] rd_data_b,
    input  logic                  wb_en,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  host_en,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_data
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_reg [DEPTH];
    logic [DEPTH-1:0]      wb_hit;
    logic [DEPTH-1:0]      host_hit;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_row
            assign wb_hit[gi]   = wb_en   && (wb_addr   == ADDR_WIDTH'(gi));
            assign host_hit[gi] = host_en && (host_addr == ADDR_WIDTH'(gi));

            // Per-register update: writeback first, then host write.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    regs_reg[gi] <= '0;
                end else if (wb_hit[gi]) begin
                    regs_reg[gi] <= wb_data;
                end else if (host_hit[gi]) begin
                    regs_reg[gi] <= host_data;
                end
            end
        end
    endgenerate

    // Reads return the pre-write contents of the current cycle.
    assign rd_data_a = regs_reg[rd_addr_a];
    assign rd_data_b = regs_reg[rd_addr_b];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command front-end for ALU_TOP. Fetches operands from the local register
// file, presents them to the ALU, waits out the ALU latency, captures the
// result of the unit selected by the opcode, optionally writes it back and
// returns it on a valid/ready response channel.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH_IN_DATA        = 16,
    parameter int WIDTH_OUT_DATA_ARITH = 32,
    parameter int WIDTH_OUT_DATA_LOGIC = 16,
    parameter int WIDTH_OUT_DATA_CMP   = 16,
    parameter int WIDTH_OUT_DATA_SHIFT = 16,
    parameter int ADDR_WIDTH           = 3,
    parameter int ALU_LAT              = 1
) (
    input  logic                            CLK,
    input  logic                            RST,
    alu_cmd_sequencer_if.slave              bus,
    output logic [WIDTH_IN_DATA-1:0]        ALU_A,
    output logic [WIDTH_IN_DATA-1:0]        ALU_B,
    output logic [OP_WIDTH-1:0]             ALU_FUN,
    input  logic [WIDTH_OUT_DATA_ARITH-1:0] Arith_OUT,
    input  logic [WIDTH_OUT_DATA_LOGIC-1:0] Logic_OUT,
    input  logic [WIDTH_OUT_DATA_CMP-1:0]   CMP_OUT,
    input  logic [WIDTH_OUT_DATA_SHIFT-1:0] SHIFT_OUT,
    input  logic                            Arith_Flag,
    input  logic                            Logic_Flag,
    input  logic                            CMP_Flag,
    input  logic                            SHIFT_Flag
);
    // Counter only needs to hold ALU_LAT.
    localparam int CNT_W = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);

    seq_state_t                      state_reg;
    logic [CNT_W-1:0]                cnt_reg;
    logic [ADDR_WIDTH-1:0]           dst_reg;
    logic                            wb_en_reg;
    alu_unit_t                       unit_reg;
    logic                            rsp_valid_reg;
    logic [WIDTH_OUT_DATA_ARITH-1:0] rsp_data_reg;
    logic                            rsp_err_reg;

    logic [WIDTH_IN_DATA-1:0]        rd_data_a;
    logic [WIDTH_IN_DATA-1:0]        rd_data_b;
    logic                            cmd_accept;
    logic                            capture;
    logic                            capture_flag;
    logic [WIDTH_OUT_DATA_ARITH-1:0] capture_data;
    logic                            wb_fire;

    assign bus.cmd_ready = (state_reg == IDLE);
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_data  = rsp_data_reg;
    assign bus.rsp_err   = rsp_err_reg;

    assign cmd_accept = bus.cmd_valid && (state_reg == IDLE);
    assign capture    = (state_reg == WAIT) && (cnt_reg == '0);
    // A missing unit flag suppresses writeback; the response carries rsp_err.
    assign wb_fire    = capture && capture_flag && wb_en_reg;

    // Select the expected unit's result and flag; zero the data if the flag is absent.
    always_comb begin
        capture_flag = 1'b0;
        capture_data = '0;
        case (unit_reg)
            UNIT_ARITH: begin
                capture_flag = Arith_Flag;
                capture_data = Arith_OUT;
            end
            UNIT_LOGIC: begin
                capture_flag = Logic_Flag;
                capture_data = WIDTH_OUT_DATA_ARITH'(Logic_OUT);
            end
            UNIT_CMP: begin
                capture_flag = CMP_Flag;
                capture_data = WIDTH_OUT_DATA_ARITH'(CMP_OUT);
            end
            UNIT_SHIFT: begin
                capture_flag = SHIFT_Flag;
                capture_data = WIDTH_OUT_DATA_ARITH'(SHIFT_OUT);
            end
            default: begin
                capture_flag = 1'b0;
                capture_data = '0;
            end
        endcase
        if (!capture_flag) begin
            capture_data = '0;
        end
    end

    alu_seq_regfile #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (WIDTH_IN_DATA)
    ) u_regfile (
        .clk       (CLK),
        .rst_n     (RST),
        .rd_addr_a (bus.cmd_src_a),
        .rd_addr_b (bus.cmd_src_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .wb_en     (wb_fire),
        .wb_addr   (dst_reg),
        .wb_data   (capture_data[WIDTH_IN_DATA-1:0]),
        .host_en   (bus.wr_en),
        .host_addr (bus.wr_addr),
        .host_data (bus.wr_data)
    );

    // Sequencer FSM: accept command, wait ALU latency, capture, hold response.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            dst_reg       <= '0;
            wb_en_reg     <= 1'b0;
            unit_reg      <= UNIT_ARITH;
            ALU_A         <= '0;
            ALU_B         <= '0;
            ALU_FUN       <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cmd_accept) begin
                        ALU_A     <= rd_data_a;
                        ALU_B     <= rd_data_b;
                        ALU_FUN   <= bus.cmd_op;
                        dst_reg   <= bus.cmd_dst;
                        wb_en_reg <= bus.cmd_wb_en;
                        unit_reg  <= op_unit(bus.cmd_op);
                        cnt_reg   <= CNT_W'(ALU_LAT);
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    // ALU inputs stay untouched until the next accept.
                    if (!capture) begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end else begin
                        rsp_data_reg  <= capture_data;
                        rsp_err_reg   <= !capture_flag;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with a behavioural ALU_TOP
// stand-in and a register-file reference model.
`timescale 1ns/1ps
module tb_alu_cmd_sequencer;
    import alu_seq_pkg::*;

    localparam int WIN  = 16;
    localparam int WAR  = 32;
    localparam int AW   = 3;
    localparam int LAT  = 1;
    localparam int NREG = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_cmd_sequencer_if #(.WIDTH_IN_DATA(WIN), .WIDTH_OUT_DATA_ARITH(WAR), .ADDR_WIDTH(AW)) bus ();

    logic [15:0] alu_a, alu_b;
    logic [3:0]  alu_fun;
    logic [31:0] arith_out;
    logic [15:0] logic_out, cmp_out, shift_out;
    logic        arith_flag, logic_flag, cmp_flag, shift_flag;
    bit          kill_flag;

    int          n_checks;
    int          n_pass;
    logic [15:0] ref_regs [NREG];

    alu_cmd_sequencer #(
        .WIDTH_IN_DATA(WIN), .WIDTH_OUT_DATA_ARITH(WAR), .WIDTH_OUT_DATA_LOGIC(16),
        .WIDTH_OUT_DATA_CMP(16), .WIDTH_OUT_DATA_SHIFT(16), .ADDR_WIDTH(AW), .ALU_LAT(LAT)
    ) dut (
        .CLK(clk), .RST(rst_n), .bus(bus),
        .ALU_A(alu_a), .ALU_B(alu_b), .ALU_FUN(alu_fun),
        .Arith_OUT(arith_out), .Logic_OUT(logic_out), .CMP_OUT(cmp_out), .SHIFT_OUT(shift_out),
        .Arith_Flag(arith_flag), .Logic_Flag(logic_flag), .CMP_Flag(cmp_flag), .SHIFT_Flag(shift_flag)
    );

    // ALU_TOP semantics: signed arithmetic, 16-bit logic/compare/shift results.
    function automatic logic [31:0] alu_eval(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        int sa, sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (op)
            4'b0000: return 32'(sa + sb);
            4'b0001: return 32'(sa - sb);
            4'b0010: return 32'(sa * sb);
            4'b0011: return (sb == 0) ? 32'd0 : 32'(sa / sb);
            4'b0100: return {16'h0, a & b};
            4'b0101: return {16'h0, a | b};
            4'b0110: return {16'h0, ~(a & b)};
            4'b0111: return {16'h0, ~(a | b)};
            4'b1000: return 32'd0;
            4'b1001: return (a == b) ? 32'd1 : 32'd0;
            4'b1010: return (sa > sb) ? 32'd2 : 32'd0;
            4'b1011: return (sa < sb) ? 32'd3 : 32'd0;
            4'b1100: return {16'h0, a >> 1};
            4'b1101: return {16'h0, a << 1};
            4'b1110: return {16'h0, b >> 1};
            default: return {16'h0, b << 1};
        endcase
    endfunction

    // One-stage ALU: selected unit gets the result and flag, other units get noise.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arith_out <= '0; logic_out <= '0; cmp_out <= '0; shift_out <= '0;
            arith_flag <= 1'b0; logic_flag <= 1'b0; cmp_flag <= 1'b0; shift_flag <= 1'b0;
        end else begin : alu_stage
            logic [31:0] r;
            r = alu_eval(alu_fun, alu_a, alu_b);
            arith_out <= $urandom; logic_out <= 16'($urandom);
            cmp_out <= 16'($urandom); shift_out <= 16'($urandom);
            arith_flag <= 1'b0; logic_flag <= 1'b0; cmp_flag <= 1'b0; shift_flag <= 1'b0;
            case (alu_fun[3:2])
                2'b00: begin arith_out <= r;        arith_flag <= !kill_flag; end
                2'b01: begin logic_out <= r[15:0];  logic_flag <= !kill_flag; end
                2'b10: begin cmp_out   <= r[15:0];  cmp_flag   <= !kill_flag; end
                default: begin shift_out <= r[15:0]; shift_flag <= !kill_flag; end
            endcase
        end
    end

    task automatic host_write(input int addr, input logic [15:0] data);
        bus.wr_en = 1'b1; bus.wr_addr = 3'(addr); bus.wr_data = data;
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
        ref_regs[addr] = data;
        $display("host write r%0d = %h", addr, data);
    endtask

    // Issue one command; returns captured data/err and edges from accept to rsp_valid.
    task automatic issue_cmd(input logic [3:0] op, input int a, input int b, input int dst, input bit wb,
                             input bit complete, output logic [31:0] data, output logic err, output int lat);
        bus.cmd_op = op; bus.cmd_src_a = 3'(a); bus.cmd_src_b = 3'(b);
        bus.cmd_dst = 3'(dst); bus.cmd_wb_en = wb; bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        lat = 0;
        while (!bus.rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        data = bus.rsp_data;
        err  = bus.rsp_err;
        if (complete) begin
            bus.rsp_ready = 1'b1;
            @(posedge clk); #1;
            bus.rsp_ready = 1'b0;
        end
        $display("cmd op=%b a=%0d b=%0d dst=%0d wb=%0b -> data=%h err=%0b lat=%0d", op, a, b, dst, wb, data, err, lat);
    endtask

    task automatic read_reg(input int addr, output logic [31:0] data);
        logic e; int l;
        issue_cmd(OP_OR, addr, addr, 0, 1'b0, 1'b1, data, e, l);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); else n_pass++;
        n_checks++; if (bus.rsp_data !== 32'h0) $display("FAIL reset_rsp_data: got %h want 0", bus.rsp_data); else n_pass++;
        n_checks++; if (bus.rsp_err !== 1'b0) $display("FAIL reset_rsp_err: got %b want 0", bus.rsp_err); else n_pass++;
        n_checks++; if ({alu_a, alu_b, alu_fun} !== 36'h0) $display("FAIL reset_alu_inputs: got %h %h %h want 0", alu_a, alu_b, alu_fun); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready); else n_pass++;
        for (int i = 0; i < NREG; i++) begin
            ref_regs[i] = 16'h0;
            read_reg(i, v);
            n_checks++; if (v !== 32'h0) $display("FAIL reset_reg%0d: got %h want 0", i, v); else n_pass++;
        end
    endtask

    task automatic test_add_wb();
        logic [31:0] d; logic e; int l;
        host_write(0, 16'hFFFB);
        host_write(1, 16'hFFF9);
        issue_cmd(OP_ADD, 0, 1, 2, 1'b1, 1'b1, d, e, l);
        n_checks++; if (l !== 2) $display("FAIL add_latency: got %0d want 2", l); else n_pass++;
        n_checks++; if (d !== 32'hFFFFFFF4) $display("FAIL add_data: got %h want FFFFFFF4", d); else n_pass++;
        n_checks++; if (e !== 1'b0) $display("FAIL add_err: got %b want 0", e); else n_pass++;
        ref_regs[2] = 16'hFFF4;
        read_reg(2, d);
        n_checks++; if (d !== 32'h0000FFF4) $display("FAIL add_writeback_r2: got %h want 0000FFF4", d); else n_pass++;
    endtask

    task automatic test_mul_sub();
        logic [31:0] d; logic e; int l;
        host_write(3, 16'h0007);
        issue_cmd(OP_MUL, 0, 3, 0, 1'b0, 1'b1, d, e, l);
        n_checks++; if (d !== 32'hFFFFFFDD) $display("FAIL mul_data: got %h want FFFFFFDD", d); else n_pass++;
        issue_cmd(OP_SUB, 3, 0, 0, 1'b0, 1'b1, d, e, l);
        n_checks++; if (d !== 32'h0000000C) $display("FAIL sub_data: got %h want 0000000C", d); else n_pass++;
    endtask

    task automatic test_shift_or();
        logic [31:0] d; logic e; int l;
        host_write(4, 16'h0005);
        issue_cmd(OP_SHR_A, 4, 0, 0, 1'b0, 1'b1, d, e, l);
        n_checks++; if (d !== 32'h00000002) $display("FAIL shr_data: got %h want 00000002", d); else n_pass++;
        issue_cmd(OP_OR, 4, 3, 0, 1'b0, 1'b1, d, e, l);
        n_checks++; if (d !== 32'h00000007) $display("FAIL or_data: got %h want 00000007", d); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] d; logic e; int l;
        int bad_valid, bad_data, bad_ready, bad_fun;
        issue_cmd(OP_ADD, 0, 1, 0, 1'b0, 1'b0, d, e, l);
        n_checks++; if (d !== 32'hFFFFFFF4) $display("FAIL hold_first_data: got %h want FFFFFFF4", d); else n_pass++;
        // A pending command must not be taken while the response is held.
        bus.cmd_op = OP_SUB; bus.cmd_src_a = 3'd3; bus.cmd_src_b = 3'd0; bus.cmd_wb_en = 1'b0; bus.cmd_valid = 1'b1;
        bad_valid = 0; bad_data = 0; bad_ready = 0; bad_fun = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid !== 1'b1) bad_valid++;
            if (bus.rsp_data !== 32'hFFFFFFF4) bad_data++;
            if (bus.cmd_ready !== 1'b0) bad_ready++;
            if (alu_fun !== OP_ADD) bad_fun++;
        end
        n_checks++; if (bad_valid != 0) $display("FAIL hold_rsp_valid: dropped in %0d of 5 cycles, want 0", bad_valid); else n_pass++;
        n_checks++; if (bad_data != 0) $display("FAIL hold_rsp_data: changed in %0d of 5 cycles, want 0", bad_data); else n_pass++;
        n_checks++; if (bad_ready != 0) $display("FAIL hold_cmd_ready: high in %0d of 5 cycles, want 0", bad_ready); else n_pass++;
        n_checks++; if (bad_fun != 0) $display("FAIL hold_alu_fun: changed in %0d of 5 cycles, want 0", bad_fun); else n_pass++;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL release_rsp_valid: got %b want 0", bus.rsp_valid); else n_pass++;
        n_checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL release_cmd_ready: got %b want 1", bus.cmd_ready); else n_pass++;
        n_checks++; if (bus.rsp_data !== 32'hFFFFFFF4) $display("FAIL idle_rsp_data: got %h want FFFFFFF4", bus.rsp_data); else n_pass++;
        issue_cmd(OP_SUB, 3, 0, 0, 1'b0, 1'b1, d, e, l);
        n_checks++; if (l !== 2) $display("FAIL b2b_latency: got %0d want 2", l); else n_pass++;
        n_checks++; if (d !== 32'h0000000C) $display("FAIL b2b_data: got %h want 0000000C", d); else n_pass++;
    endtask

    task automatic test_flag_err();
        logic [31:0] d; logic e; int l;
        host_write(5, 16'h5A5A);
        kill_flag = 1'b1;
        issue_cmd(OP_AND, 0, 1, 5, 1'b1, 1'b1, d, e, l);
        kill_flag = 1'b0;
        n_checks++; if (e !== 1'b1) $display("FAIL err_flag: got %b want 1", e); else n_pass++;
        n_checks++; if (d !== 32'h0) $display("FAIL err_data: got %h want 0", d); else n_pass++;
        n_checks++; if (l !== 2) $display("FAIL err_latency: got %0d want 2", l); else n_pass++;
        read_reg(5, d);
        n_checks++; if (d !== 32'h00005A5A) $display("FAIL err_no_writeback_r5: got %h want 00005A5A", d); else n_pass++;
    endtask

    task automatic test_wb_collision();
        logic [31:0] d;
        host_write(2, 16'h0F0F);
        bus.cmd_op = OP_ADD; bus.cmd_src_a = 3'd0; bus.cmd_src_b = 3'd1;
        bus.cmd_dst = 3'd2; bus.cmd_wb_en = 1'b1; bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        // Overwrite a source after the accept edge.
        bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 16'h1234;
        @(posedge clk); #1;
        // Host write to the destination on the capture edge.
        bus.wr_addr = 3'd2; bus.wr_data = 16'hAAAA;
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
        n_checks++; if (bus.rsp_valid !== 1'b1) $display("FAIL coll_rsp_valid: got %b want 1", bus.rsp_valid); else n_pass++;
        n_checks++; if (bus.rsp_data !== 32'hFFFFFFF4) $display("FAIL coll_operand_snapshot: got %h want FFFFFFF4", bus.rsp_data); else n_pass++;
        $display("collision cmd add r0,r1 -> r2 data=%h", bus.rsp_data);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        ref_regs[0] = 16'h1234;
        ref_regs[2] = 16'hFFF4;
        read_reg(2, d);
        n_checks++; if (d !== 32'h0000FFF4) $display("FAIL coll_writeback_wins: got %h want 0000FFF4", d); else n_pass++;
        read_reg(0, d);
        n_checks++; if (d !== 32'h00001234) $display("FAIL coll_host_write_r0: got %h want 00001234", d); else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] d, exp; logic e; int l;
        logic [3:0] op; int a, b, dst; bit wb, kill;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) == 0) host_write($urandom_range(0, NREG - 1), 16'($urandom));
            op = 4'($urandom);
            a = $urandom_range(0, NREG - 1);
            b = $urandom_range(0, NREG - 1);
            dst = $urandom_range(0, NREG - 1);
            wb = 1'($urandom_range(0, 1));
            kill = ($urandom_range(0, 7) == 0);
            exp = kill ? 32'h0 : alu_eval(op, ref_regs[a], ref_regs[b]);
            kill_flag = kill;
            issue_cmd(op, a, b, dst, wb, 1'b1, d, e, l);
            kill_flag = 1'b0;
            n_checks++; if (d !== exp) $display("FAIL rand%0d_data: got %h want %h", n, d, exp); else n_pass++;
            n_checks++; if (e !== kill) $display("FAIL rand%0d_err: got %b want %b", n, e, kill); else n_pass++;
            n_checks++; if (l !== LAT + 1) $display("FAIL rand%0d_latency: got %0d want %0d", n, l, LAT + 1); else n_pass++;
            if (wb && !kill) ref_regs[dst] = exp[15:0];
        end
        for (int i = 0; i < NREG; i++) begin
            read_reg(i, d);
            n_checks++; if (d !== {16'h0, ref_regs[i]}) $display("FAIL rand_final_r%0d: got %h want %h", i, d, {16'h0, ref_regs[i]}); else n_pass++;
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] d; int seen;
        host_write(0, 16'h0F0F);
        host_write(1, 16'h1111);
        bus.cmd_op = OP_SUB; bus.cmd_src_a = 3'd0; bus.cmd_src_b = 3'd1;
        bus.cmd_dst = 3'd3; bus.cmd_wb_en = 1'b1; bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        n_checks++; if (alu_fun !== OP_SUB) $display("FAIL abort_accepted: alu_fun got %b want 0001", alu_fun); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL abort_rsp_valid: got %b want 0", bus.rsp_valid); else n_pass++;
        n_checks++; if (alu_fun !== 4'b0) $display("FAIL abort_alu_fun: got %b want 0", alu_fun); else n_pass++;
        n_checks++; if (alu_a !== 16'h0) $display("FAIL abort_alu_a: got %h want 0", alu_a); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid === 1'b1) seen++;
        end
        n_checks++; if (seen != 0) $display("FAIL abort_no_response: rsp_valid seen %0d cycles want 0", seen); else n_pass++;
        n_checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL abort_cmd_ready: got %b want 1", bus.cmd_ready); else n_pass++;
        for (int i = 0; i < NREG; i++) begin
            ref_regs[i] = 16'h0;
            read_reg(i, d);
            n_checks++; if (d !== 32'h0) $display("FAIL abort_reg%0d: got %h want 0", i, d); else n_pass++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        kill_flag = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_src_a = '0; bus.cmd_src_b = '0;
        bus.cmd_dst = '0; bus.cmd_wb_en = 1'b0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < NREG; i++) ref_regs[i] = 16'h0;
        test_reset();
        test_add_wb();
        test_mul_sub();
        test_shift_or();
        test_back_to_back();
        test_flag_err();
        test_wb_collision();
        test_random();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks done", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
